// File: rtl/fifo_word_packer_if.sv
// Stream bundle between a show-ahead FIFO, the word packer
// and the wide beat consumer.
interface fifo_word_packer_if #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4,
  parameter int CNT_W = $clog2(PACK + 1)
);
  logic [WIDTH-1:0]      fifo_data;
  logic                  fifo_valid;
  logic                  fifo_ren;
  logic                  flush;
  logic [PACK*WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_W-1:0]      out_count;
  logic                  out_last;
  logic                  busy;

  modport master (
    input  fifo_data,
    input  fifo_valid,
    input  flush,
    input  out_ready,
    output fifo_ren,
    output out_data,
    output out_valid,
    output out_count,
    output out_last,
    output busy
  );

  modport slave (
    output fifo_data,
    output fifo_valid,
    output flush,
    output out_ready,
    input  fifo_ren,
    input  out_data,
    input  out_valid,
    input  out_count,
    input  out_last,
    input  busy
  );
endinterface

// File: rtl/fifo_word_packer.sv
// Drains a show-ahead FIFO one word per cycle and packs PACK words
// into one wide valid/ready beat; flush closes a partial beat early.
module fifo_word_packer #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4,
  parameter int CNT_W = $clog2(PACK + 1)
) (
  input  logic               clk,
  input  logic               rst,
  fifo_word_packer_if.master bus
);
  localparam int IDX_W = (PACK > 1) ? $clog2(PACK) : 1;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACK - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK);

  typedef logic [PACK-1:0][WIDTH-1:0] lanes_t;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  lanes_t           lanes_q, lanes_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             pend_q, pend_d;

  logic             in_hold;
  logic             pop;
  logic             flush_any;
  logic             at_last;
  logic [CNT_W-1:0] n_fill;

  assign in_hold = (state_q == HOLD);

  // The slot frees up in the same cycle the held beat is taken.
  assign pop = ~rst & bus.fifo_valid
             & (~in_hold | bus.out_ready);

  assign flush_any = bus.flush | pend_q;
  assign at_last   = (idx_q == IDX_LAST);
  assign n_fill    = CNT_W'(idx_q) + CNT_W'(pop);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    pend_d  = pend_q;

    unique case (state_q)
      FILL: begin
        if (pop) begin
          lanes_d[idx_q] = bus.fifo_data;
        end
        if (flush_any) begin
          pend_d = 1'b0;
          if (n_fill != '0) begin
            state_d = HOLD;
            cnt_d   = n_fill;
            last_d  = 1'b1;
            idx_d   = '0;
          end
        end else if (pop) begin
          if (at_last) begin
            state_d = HOLD;
            cnt_d   = CNT_FULL;
            last_d  = 1'b0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end

      HOLD: begin
        if (bus.flush) begin
          pend_d = 1'b1;
        end
        if (bus.out_ready) begin
          state_d = FILL;
          lanes_d = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
          if (pop) begin
            lanes_d[0] = bus.fifo_data;
            if (PACK == 1) begin
              state_d = HOLD;
              cnt_d   = CNT_FULL;
            end else begin
              idx_d = IDX_ONE;
            end
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      lanes_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.fifo_ren  = pop;
  assign bus.out_data  = lanes_q;
  assign bus.out_valid = in_hold;
  assign bus.out_count = cnt_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (idx_q != '0) | in_hold | pend_q;

`ifndef SYNTHESIS
  a_pop_needs_valid: assert property (
    @(posedge clk) disable iff (rst)
      pop |-> bus.fifo_valid);

  a_hold_stable: assert property (
    @(posedge clk) disable iff (rst)
      (in_hold && !bus.out_ready) |=>
        (in_hold && $stable(lanes_q)
         && $stable(cnt_q) && $stable(last_q)));
`endif
endmodule
